// File: rtl/effect_panel_plotter.sv
// effect_panel_plotter: draws per-channel status boxes and level bars as a pixel stream.
// Channels are queued through pending bits and served lowest index first, one at a time.
module effect_panel_plotter #(
    parameter int NUM_CH    = 3,
    parameter int LEVEL_W   = 7,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOUR_W  = 12,
    parameter int BOX_X0    = 25,
    parameter int BOX_Y0    = 21,
    parameter int BOX_W     = 17,
    parameter int BOX_H     = 7,
    parameter int CH_PITCH  = 40,
    parameter int BAR_H     = 14,
    parameter int BAR_Y_BOT = 51,
    parameter logic [COLOUR_W-1:0] ON_COL  = 12'h9d5,
    parameter logic [COLOUR_W-1:0] OFF_COL = 12'h000,
    parameter logic [COLOUR_W-1:0] BAR_COL = 12'ha35,
    parameter logic [COLOUR_W-1:0] BAR_BG  = 12'h333
) (
    input  logic                        Clock,
    input  logic                        Resetn,
    input  logic [NUM_CH-1:0]           On,
    input  logic [NUM_CH-1:0]           Go,
    input  logic                        Refresh,
    input  logic [NUM_CH*LEVEL_W-1:0]   Level,
    output logic [X_W-1:0]              x,
    output logic [Y_W-1:0]              y,
    output logic [COLOUR_W-1:0]         colour,
    output logic                        writeEn,
    output logic                        Busy,
    output logic                        Done
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CX_W = $clog2(BOX_W + 1);
    localparam int CY_W = $clog2(BOX_H + 1);
    localparam int K_W  = $clog2(BAR_H + 1);

    typedef enum logic [1:0] {IDLE, BOX, BAR} state_t;

    state_t                 state;
    logic [NUM_CH-1:0]      pending;
    logic [NUM_CH-1:0]      sel_mask;
    logic [NUM_CH-1:0]      clr_mask;
    logic                   sel_valid;
    logic [CH_W-1:0]        sel;
    logic [LEVEL_W-1:0]     sel_level;
    logic [X_W-1:0]         base_x;
    logic [LEVEL_W-1:0]     level_l;
    logic [CX_W-1:0]        cx;
    logic [CY_W-1:0]        cy;
    logic [K_W-1:0]         k;

    function automatic logic [X_W-1:0] ch_base(input logic [CH_W-1:0] c);
        return X_W'(BOX_X0 + int'(c) * CH_PITCH);
    endfunction

    // k below min(level, BAR_H) reduces to k below level since k never reaches BAR_H
    function automatic logic [COLOUR_W-1:0] bar_colour(input logic [K_W-1:0] kk,
                                                       input logic [LEVEL_W-1:0] lv);
        return (32'(kk) < 32'(lv)) ? BAR_COL : BAR_BG;
    endfunction

    // Lowest-index pending channel and the bit to clear when it is taken
    always_comb begin
        sel_valid = 1'b0;
        sel       = '0;
        sel_mask  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (pending[i] && !sel_valid) begin
                sel_valid   = 1'b1;
                sel         = CH_W'(i);
                sel_mask[i] = 1'b1;
            end
        end
        sel_level = Level[int'(sel)*LEVEL_W +: LEVEL_W];
        clr_mask  = (state == IDLE) ? sel_mask : '0;
    end

    // Pending requests; a new Go wins over the clear on the same edge
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | Go | {NUM_CH{Refresh}};
        end
    end

    // Drawing FSM: box raster, then bar column, then one Done cycle
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            writeEn <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            base_x  <= '0;
            level_l <= '0;
            cx      <= '0;
            cy      <= '0;
            k       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    Done    <= 1'b0;
                    writeEn <= 1'b0;
                    if (sel_valid) begin
                        state   <= BOX;
                        Busy    <= 1'b1;
                        base_x  <= ch_base(sel);
                        level_l <= sel_level;
                        cx      <= '0;
                        cy      <= '0;
                        x       <= ch_base(sel);
                        y       <= Y_W'(BOX_Y0);
                        colour  <= On[sel] ? ON_COL : OFF_COL;
                        writeEn <= 1'b1;
                    end else begin
                        Busy <= 1'b0;
                    end
                end
                BOX: begin
                    if (cx != CX_W'(BOX_W - 1)) begin
                        cx <= cx + CX_W'(1);
                        x  <= x + X_W'(1);
                    end else if (cy != CY_W'(BOX_H - 1)) begin
                        cx <= '0;
                        cy <= cy + CY_W'(1);
                        x  <= base_x;
                        y  <= y + Y_W'(1);
                    end else begin
                        state  <= BAR;
                        k      <= '0;
                        x      <= base_x + X_W'(BOX_W / 2);
                        y      <= Y_W'(BAR_Y_BOT);
                        colour <= bar_colour('0, level_l);
                    end
                end
                BAR: begin
                    if (k != K_W'(BAR_H - 1)) begin
                        k      <= k + K_W'(1);
                        y      <= y - Y_W'(1);
                        colour <= bar_colour(k + K_W'(1), level_l);
                    end else begin
                        state   <= IDLE;
                        writeEn <= 1'b0;
                        Done    <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    writeEn <= 1'b0;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_effect_panel_plotter.sv
// Scoreboard bench for effect_panel_plotter: expected pixels are queued when a draw is
// requested and popped by a monitor as writeEn pixels appear.
module tb_effect_panel_plotter;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b1;
    logic [2:0]  On = '0;
    logic [2:0]  Go = '0;
    logic        Refresh = 1'b0;
    logic [20:0] Level = '0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [11:0] colour;
    logic        writeEn, Busy, Done;

    effect_panel_plotter #(.NUM_CH(3), .LEVEL_W(7)) dut (
        .Clock(Clock), .Resetn(Resetn), .On(On), .Go(Go), .Refresh(Refresh),
        .Level(Level), .x(x), .y(y), .colour(colour),
        .writeEn(writeEn), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    int checks = 0, errors = 0, cyc = 0;
    int wr_cnt = 0, first_wr = -1, last_wr = -1, go_cyc = 0;
    logic [26:0] sb[$];
    logic [26:0] exp_pix, prev_pix;
    logic        prev_ok = 1'b0;

    always @(posedge Clock) cyc++;

    // Pixel monitor: compares every written pixel, and checks outputs hold while idle
    always @(negedge Clock) begin
        if (Resetn && writeEn) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pixel: got (%0d,%0d,%h), none expected", x, y, colour);
            end else begin
                exp_pix = sb.pop_front();
                if ({x, y, colour} !== exp_pix) begin
                    errors++;
                    $display("FAIL pixel #%0d: got (%0d,%0d,%h) expected (%0d,%0d,%h)", wr_cnt,
                             x, y, colour, exp_pix[26:19], exp_pix[18:12], exp_pix[11:0]);
                end
            end
        end else if (Resetn && prev_ok) begin
            checks++;
            if ({x, y, colour} !== prev_pix) begin
                errors++;
                $display("FAIL hold_when_idle: got (%0d,%0d,%h) was (%0d,%0d,%h)", x, y, colour,
                         prev_pix[26:19], prev_pix[18:12], prev_pix[11:0]);
            end
        end
        prev_pix = {x, y, colour};
        prev_ok  = Resetn;
    end

    task automatic push_channel(input int ch, input int on, input int lvl);
        for (int yy = 0; yy < 7; yy++)
            for (int xx = 0; xx < 17; xx++)
                sb.push_back({8'(25 + ch*40 + xx), 7'(21 + yy), (on != 0) ? 12'h9d5 : 12'h000});
        for (int kk = 0; kk < 14; kk++)
            sb.push_back({8'(25 + ch*40 + 8), 7'(51 - kk), (kk < lvl) ? 12'ha35 : 12'h333});
    endtask

    task automatic set_level(input int ch, input int v);
        Level[ch*7 +: 7] = 7'(v);
    endtask

    task automatic clear_stats();
        wr_cnt = 0; first_wr = -1; last_wr = -1;
    endtask

    task automatic pulse(input logic [2:0] go_mask, input logic refr, input int cycles);
        @(posedge Clock); #1;
        go_cyc  = cyc;
        Go      = go_mask;
        Refresh = refr;
        repeat (cycles) @(posedge Clock);
        #1;
        Go      = '0;
        Refresh = 1'b0;
    endtask

    task automatic run_until_done(input int n, input int budget, output int dones, output int gaps);
        bit started = 0;
        dones = 0; gaps = 0;
        for (int i = 0; i < budget && dones < n; i++) begin
            @(negedge Clock);
            if (Done) dones++;
            if (started && !Busy) gaps++;
            if (writeEn) started = 1;
        end
        if (dones < n) $display("FAIL wait_done: timed out with %0d of %0d Done pulses", dones, n);
        repeat (5) @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        #2 Resetn = 1'b0;
        #1;
        checks++; if (writeEn !== 1'b0) begin errors++; $display("FAIL reset_writeEn: got %b want 0", writeEn); end
        checks++; if (Busy !== 1'b0)    begin errors++; $display("FAIL reset_Busy: got %b want 0", Busy); end
        checks++; if (Done !== 1'b0)    begin errors++; $display("FAIL reset_Done: got %b want 0", Done); end
        checks++; if ({x, y, colour} !== 27'd0) begin errors++; $display("FAIL reset_pixel: got (%0d,%0d,%h) want 0", x, y, colour); end
        repeat (3) @(posedge Clock);
        #1 Resetn = 1'b1;
        repeat (3) @(posedge Clock);
        checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL reset_no_pixels: got %0d want 0", wr_cnt); end
    endtask

    task automatic test_single();
        int d, g;
        clear_stats();
        On[0] = 1'b1; set_level(0, 5);
        push_channel(0, 1, 5);
        pulse(3'b001, 1'b0, 1);
        run_until_done(1, 400, d, g);
        checks++; if (d !== 1) begin errors++; $display("FAIL single_done: got %0d want 1", d); end
        checks++; if (wr_cnt !== 133) begin errors++; $display("FAIL single_count: got %0d want 133", wr_cnt); end
        checks++; if (last_wr - first_wr + 1 !== 133) begin errors++; $display("FAIL single_contiguous: span %0d want 133", last_wr - first_wr + 1); end
        checks++; if (first_wr - go_cyc !== 2) begin errors++; $display("FAIL single_latency: got %0d want 2", first_wr - go_cyc); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", Busy); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL single_leftover: %0d pixels missing", sb.size()); end
    endtask

    task automatic test_saturation();
        int d, g;
        clear_stats();
        On[1] = 1'b0; set_level(1, 127);
        push_channel(1, 0, 127);
        pulse(3'b010, 1'b0, 1);
        run_until_done(1, 400, d, g);
        checks++; if (d !== 1) begin errors++; $display("FAIL sat_done: got %0d want 1", d); end
        checks++; if (wr_cnt !== 133) begin errors++; $display("FAIL sat_count: got %0d want 133", wr_cnt); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL sat_leftover: %0d pixels missing", sb.size()); end
    endtask

    task automatic test_back_to_back();
        int d, g;
        clear_stats();
        On[0] = 1'b1; set_level(0, 5);
        On[2] = 1'b1; set_level(2, 9);
        push_channel(0, 1, 5);
        push_channel(2, 1, 9);
        pulse(3'b101, 1'b0, 1);
        run_until_done(2, 800, d, g);
        checks++; if (d !== 2) begin errors++; $display("FAIL b2b_done: got %0d want 2", d); end
        checks++; if (g !== 0) begin errors++; $display("FAIL b2b_busy_gap: got %0d low cycles want 0", g); end
        checks++; if (wr_cnt !== 266) begin errors++; $display("FAIL b2b_count: got %0d want 266", wr_cnt); end
        checks++; if (last_wr - first_wr + 1 !== 267) begin errors++; $display("FAIL b2b_span: got %0d want 267", last_wr - first_wr + 1); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", Busy); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL b2b_leftover: %0d pixels missing", sb.size()); end
    endtask

    task automatic test_redraw_mid_draw();
        int d, g, n;
        clear_stats();
        On[0] = 1'b1; set_level(0, 5);
        push_channel(0, 1, 5);
        push_channel(0, 1, 14);
        pulse(3'b001, 1'b0, 1);
        n = 0;
        while (wr_cnt < 50 && n < 200) begin @(posedge Clock); #1; n++; end
        checks++; if (wr_cnt < 50) begin errors++; $display("FAIL redraw_start: got %0d pixels want 50", wr_cnt); end
        set_level(0, 14);
        pulse(3'b001, 1'b0, 1);
        run_until_done(2, 800, d, g);
        checks++; if (d !== 2) begin errors++; $display("FAIL redraw_done: got %0d want 2", d); end
        checks++; if (wr_cnt !== 266) begin errors++; $display("FAIL redraw_count: got %0d want 266", wr_cnt); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL redraw_leftover: %0d pixels missing", sb.size()); end
    endtask

    task automatic test_go_at_clear();
        int d, g;
        clear_stats();
        set_level(0, 2);
        push_channel(0, 1, 2);
        push_channel(0, 1, 2);
        pulse(3'b001, 1'b0, 2);
        run_until_done(2, 800, d, g);
        checks++; if (d !== 2) begin errors++; $display("FAIL go_at_clear_done: got %0d want 2", d); end
        checks++; if (wr_cnt !== 266) begin errors++; $display("FAIL go_at_clear_count: got %0d want 266", wr_cnt); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL go_at_clear_leftover: %0d pixels missing", sb.size()); end
    endtask

    task automatic test_reset_mid_draw();
        int n, w;
        clear_stats();
        set_level(0, 5);
        push_channel(0, 1, 5);
        pulse(3'b001, 1'b0, 1);
        n = 0;
        while (wr_cnt < 60 && n < 200) begin @(posedge Clock); #1; n++; end
        Resetn = 1'b0;
        #1;
        checks++; if (writeEn !== 1'b0) begin errors++; $display("FAIL midreset_writeEn: got %b want 0", writeEn); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midreset_Busy: got %b want 0", Busy); end
        checks++; if (wr_cnt !== 60) begin errors++; $display("FAIL midreset_pixels: got %0d want 60", wr_cnt); end
        sb.delete();
        repeat (3) @(posedge Clock);
        #1 Resetn = 1'b1;
        w = wr_cnt;
        repeat (300) @(posedge Clock);
        #1;
        checks++; if (wr_cnt !== w) begin errors++; $display("FAIL midreset_quiet: got %0d pixels want %0d", wr_cnt, w); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midreset_busy_after: got %b want 0", Busy); end
    endtask

    task automatic test_refresh();
        int d, g;
        clear_stats();
        On = 3'b101;
        set_level(0, 3); set_level(1, 20); set_level(2, 0);
        push_channel(0, 1, 3);
        push_channel(1, 0, 20);
        push_channel(2, 1, 0);
        pulse(3'b000, 1'b1, 1);
        run_until_done(3, 1500, d, g);
        checks++; if (d !== 3) begin errors++; $display("FAIL refresh_done: got %0d want 3", d); end
        checks++; if (g !== 0) begin errors++; $display("FAIL refresh_busy_gap: got %0d want 0", g); end
        checks++; if (wr_cnt !== 399) begin errors++; $display("FAIL refresh_count: got %0d want 399", wr_cnt); end
        checks++; if (last_wr - first_wr + 1 !== 401) begin errors++; $display("FAIL refresh_span: got %0d want 401", last_wr - first_wr + 1); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL refresh_leftover: %0d pixels missing", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_back_to_back();
        test_redraw_mid_draw();
        test_go_at_clear();
        test_reset_mid_draw();
        test_refresh();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
